alu_seq_mdu: RTL and testbench

- Parametrised, registered successor to the 64-bit single-cycle integer ALU.
- Adds a valid/ready handshake, registered flags and an iterative multiply unit (optional divide unit).
- Sits between the decode/issue stage and writeback.
- Single-cycle ops complete in one clock; multiply/divide take WIDTH+1 clocks.
- Accepts one operation at a time and holds its result until consumed.

---
 rtl/alu_seq_mdu.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_seq_mdu.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_mdu.sv
// alu_seq_mdu -- registered integer ALU with valid/ready handshake, registered
// flags and an iterative shift-add multiplier. Defining ALU_SEQ_DIV_EN adds an
// iterative restoring divider for DIVU/REMU; without it those opcodes return 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operation handshake; op, a, b captured on acceptance
//   out_valid/out_ready result handshake; f and flags held until consumed
//   f                   result
//   zf cf of sf pf      zero, carry, overflow, sign, parity (even) flags
//   busy                iterative operation in progress
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one multiply/divide step per clock, cnt_q runs 0..WIDTH-1
// DONE  | result and flags valid, waiting for out_ready
module alu_seq_mdu #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             cf,
  output logic             of,
  output logic             sf,
  output logic             pf,
  output logic             busy
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;
`endif

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;   // mul: running high product; div: partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;   // mul: multiplier/low product; div: dividend/quotient
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             zf_q, sf_q, pf_q;
  logic             res_ld;

  // ---------------- single-cycle datapath (operates on live inputs) --------
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] alu_f;
  logic             alu_cf, alu_of;
  logic             iter_op;

  assign shamt  = b[SHW-1:0];
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_f  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    case (op)
      OP_AND:   alu_f = a & b;
      OP_OR:    alu_f = a | b;
      OP_ADD: begin
        alu_f  = sum_w[WIDTH-1:0];
        alu_cf = sum_w[WIDTH];
        alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:   alu_f = a << shamt;
      OP_SLT:   alu_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_f = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
      OP_SUB: begin
        alu_f  = diff_w[WIDTH-1:0];
        alu_cf = diff_w[WIDTH];
        alu_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:   alu_f = a ^ b;
      OP_SRL:   alu_f = a >> shamt;
      OP_SRA:   alu_f = $signed(a) >>> shamt;
      OP_PASSB: alu_f = b;
      default:  alu_f = '0;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  assign iter_op = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
  assign iter_op = (op == OP_MUL) || (op == OP_MULHU);
`endif

  // ---------------- iterative datapath (operates on captured operands) ----
  logic [WIDTH:0]   madd_w;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] iter_f;
  logic             iter_flag;

  // Shift-add: conditionally add multiplicand to the high half, then shift
  // the whole {carry, hi, lo} right by one.
  assign madd_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   rsh_w;
  logic [WIDTH-1:0] rdiff_w;
  logic             rge;
  logic             is_div_q;

  // Restoring step: shift next dividend bit into the remainder, subtract the
  // divisor when it fits. A zero divisor always "fits", which yields an
  // all-ones quotient and leaves the dividend as remainder.
  assign rsh_w    = {hi_q, lo_q[WIDTH-1]};
  assign rge      = rsh_w >= {1'b0, b_q};
  assign rdiff_w  = rsh_w[WIDTH-1:0] - b_q;
  assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign step_hi  = is_div_q ? (rge ? rdiff_w : rsh_w[WIDTH-1:0]) : madd_w[WIDTH:1];
  assign step_lo  = is_div_q ? {lo_q[WIDTH-2:0], rge} : {madd_w[0], lo_q[WIDTH-1:1]};
`else
  assign step_hi  = madd_w[WIDTH:1];
  assign step_lo  = {madd_w[0], lo_q[WIDTH-1:1]};
`endif

  always_comb begin
    iter_f    = step_lo;
    iter_flag = (step_hi != '0);
    case (op_q)
      OP_MULHU: iter_f = step_hi;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: begin
        iter_f    = step_lo;
        iter_flag = 1'b0;
      end
      OP_REMU: begin
        iter_f    = step_hi;
        iter_flag = 1'b0;
      end
`endif
      default: iter_f = step_lo;
    endcase
  end

  // ---------------- FSM next state / datapath next values ------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    cf_d    = cf_q;
    of_d    = of_q;
    res_ld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (iter_op) begin
            hi_d    = '0;
            lo_d    = a;
            b_d     = b;
            cnt_d   = '0;
            state_d = ST_CALC;
          end else begin
            f_d     = alu_f;
            cf_d    = alu_cf;
            of_d    = alu_of;
            res_ld  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          f_d     = iter_f;
          cf_d    = iter_flag;
          of_d    = iter_flag;
          res_ld  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      f_q   <= '0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
      zf_q  <= 1'b0;
      sf_q  <= 1'b0;
      pf_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      f_q   <= f_d;
      cf_q  <= cf_d;
      of_q  <= of_d;
      // Result-derived flags only change when a new result lands, so the
      // reset value of all-zero flags survives until the first result.
      if (res_ld) begin
        zf_q <= (f_d == '0);
        sf_q <= f_d[WIDTH-1];
        pf_q <= ~^f_d;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign f         = f_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign of        = of_q;
  assign sf        = sf_q;
  assign pf        = pf_q;

endmodule

// File: tb/tb_alu_seq_mdu.sv
module tb_alu_seq_mdu;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  a = '0, b = '0;
  logic          in_ready, out_valid, zf, cf, of, sf, pf, busy;
  logic [W-1:0]  f;

  logic          in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [3:0]    op8 = 4'd0;
  logic [7:0]    a8 = '0, b8 = '0;
  logic          in_ready8, out_valid8, zf8, cf8, of8, sf8, pf8, busy8;
  logic [7:0]    f8;

  int checks = 0;
  int errors = 0;

  alu_seq_mdu #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .zf(zf), .cf(cf), .of(of), .sf(sf), .pf(pf), .busy(busy)
  );

  alu_seq_mdu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .f(f8),
    .zf(zf8), .cf(cf8), .of(of8), .sf(sf8), .pf(pf8), .busy(busy8)
  );

  // Reference: flags packed as {zf, cf, of, sf, pf}.
  function automatic bit is_iter(input logic [3:0] o);
`ifdef ALU_SEQ_DIV_EN
    return (o >= 4'd11) && (o <= 4'd14);
`else
    return (o == 4'd11) || (o == 4'd12);
`endif
  endfunction

  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [4:0] fl);
    logic [2*W-1:0]  p;
    logic signed [W+1:0] s;
    logic c, v;
    int sh;
    c = 1'b0; v = 1'b0; r = '0;
    sh = int'(y[5:0]);
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        r = x + y;
        c = ({1'b0, x} + {1'b0, y}) > {1'b0, {W{1'b1}}};
        s = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y});
        v = s != $signed({{2{r[W-1]}}, r});
      end
      4'd3: r = x << sh;
      4'd4: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd5: r = (x < y) ? 64'd1 : 64'd0;
      4'd6: begin
        r = x - y;
        c = x < y;
        s = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
        v = s != $signed({{2{r[W-1]}}, r});
      end
      4'd7: r = x ^ y;
      4'd8: r = x >> sh;
      4'd9: r = $signed(x) >>> sh;
      4'd10: r = y;
      4'd11: begin r = p[W-1:0];   c = p[2*W-1:W] != 0; v = c; end
      4'd12: begin r = p[2*W-1:W]; c = p[2*W-1:W] != 0; v = c; end
`ifdef ALU_SEQ_DIV_EN
      4'd13: r = (y == 0) ? {W{1'b1}} : x / y;
      4'd14: r = (y == 0) ? x : x % y;
`endif
      default: r = '0;
    endcase
    fl = {(r == 0), c, v, r[W-1], ($countones(r) % 2) == 0};
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] gf, output logic [4:0] gfl);
    logic [W-1:0] ef;
    logic [4:0]   efl;
    int lat, explat;
    model(o, x, y, ef, efl);
    explat = is_iter(o) ? W + 1 : 1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready op=%0d: in_ready=%b expected 1", o, in_ready);
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; a = ~x; b = ~y;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 300) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL calc_busy op=%0d: busy=%b in_ready=%b expected 1/0", o, busy, in_ready);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != explat) begin
      errors++; $display("FAIL latency op=%0d: got %0d expected %0d", o, lat, explat);
    end
    checks++;
    if (f !== ef) begin
      errors++; $display("FAIL result op=%0d a=%h b=%h: f=%h expected %h", o, x, y, f, ef);
    end
    checks++;
    if ({zf, cf, of, sf, pf} !== efl || busy !== 1'b0) begin
      errors++; $display("FAIL flags op=%0d a=%h b=%h: zcosp=%b busy=%b expected %b/0", o, x, y, {zf, cf, of, sf, pf}, busy, efl);
    end
    gf = f; gfl = {zf, cf, of, sf, pf};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL retire op=%0d: out_valid=%b in_ready=%b expected 0/1", o, out_valid, in_ready);
    end
  endtask

  task automatic run_mul8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] gf, output logic [4:0] gfl);
    logic [15:0] p;
    logic [7:0]  ef;
    logic [4:0]  efl;
    int lat;
    p = {8'd0, x} * {8'd0, y};
    ef = (o == 4'd11) ? p[7:0] : p[15:8];
    efl = {(ef == 0), (p[15:8] != 0), (p[15:8] != 0), ef[7], ($countones(ef) % 2) == 0};
    op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = ~x; b8 = ~y;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 50) begin
      checks++;
      if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
        errors++; $display("FAIL mul8_busy: busy=%b in_ready=%b expected 1/0", busy8, in_ready8);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 9) begin
      errors++; $display("FAIL mul8_latency op=%0d: got %0d expected 9", o, lat);
    end
    checks++;
    if (f8 !== ef || {zf8, cf8, of8, sf8, pf8} !== efl) begin
      errors++; $display("FAIL mul8_result op=%0d a=%h b=%h: f=%h fl=%b expected %h %b", o, x, y, f8, {zf8, cf8, of8, sf8, pf8}, ef, efl);
    end
    gf = f8; gfl = {zf8, cf8, of8, sf8, pf8};
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (f !== '0 || {zf, cf, of, sf, pf} !== 5'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset: f=%h fl=%b ov=%b busy=%b ir=%b expected 0/00000/0/0/1", f, {zf, cf, of, sf, pf}, out_valid, busy, in_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {zf, cf, of, sf, pf} !== 5'b0) begin
      errors++; $display("FAIL reset_release: ir=%b ov=%b fl=%b expected 1/0/00000", in_ready, out_valid, {zf, cf, of, sf, pf});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] gf;
    logic [4:0]   gfl;
    run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, gf, gfl);
    checks++;
    if (gf !== 64'd0 || gfl !== 5'b11001) begin
      errors++; $display("FAIL add_wrap: f=%h fl=%b expected 0 11001", gf, gfl);
    end
    run_op(4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, gf, gfl);
    checks++;
    if (gf !== 64'h8000_0000_0000_0000 || gfl !== 5'b00110) begin
      errors++; $display("FAIL add_ovf: f=%h fl=%b expected 8000000000000000 00110", gf, gfl);
    end
    run_op(4'd6, 64'd3, 64'd5, gf, gfl);
    checks++;
    if (gf !== 64'hFFFF_FFFF_FFFF_FFFE || gfl !== 5'b01010) begin
      errors++; $display("FAIL sub_borrow: f=%h fl=%b expected fffffffffffffffe 01010", gf, gfl);
    end
    run_op(4'd9, 64'h8000_0000_0000_0000, 64'h144, gf, gfl);
    checks++;
    if (gf !== 64'hF800_0000_0000_0000 || gfl !== 5'b00010) begin
      errors++; $display("FAIL sra_mask: f=%h fl=%b expected f800000000000000 00010", gf, gfl);
    end
    run_op(4'd15, 64'h1234, 64'h5678, gf, gfl);
    checks++;
    if (gf !== 64'd0 || gfl !== 5'b10001) begin
      errors++; $display("FAIL op15: f=%h fl=%b expected 0 10001", gf, gfl);
    end
    run_op(4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, gf, gfl);
    run_op(4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, gf, gfl);
    checks++;
    if (gf !== 64'hFFFF_FFFF_FFFF_FFFE || gfl[3:2] !== 2'b11) begin
      errors++; $display("FAIL mulhu_max: f=%h cf_of=%b expected fffffffffffffffe 11", gf, gfl[3:2]);
    end
  endtask

  task automatic test_mul8();
    logic [7:0] gf;
    logic [4:0] gfl;
    run_mul8(4'd11, 8'hF0, 8'h10, gf, gfl);
    checks++;
    if (gf !== 8'h00 || gfl !== 5'b11101) begin
      errors++; $display("FAIL mul8_plan: f=%h fl=%b expected 00 11101", gf, gfl);
    end
    run_mul8(4'd12, 8'hF0, 8'h10, gf, gfl);
    checks++;
    if (gf !== 8'h0F || gfl !== 5'b01101) begin
      errors++; $display("FAIL mulhu8_plan: f=%h fl=%b expected 0f 01101", gf, gfl);
    end
    for (int i = 0; i < 20; i++) begin
      run_mul8(($urandom_range(0, 1) == 0) ? 4'd11 : 4'd12, 8'($urandom), 8'($urandom), gf, gfl);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y, x2, y2, ef, ef2, gf;
    logic [4:0]   efl, efl2, gfl;
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
    model(4'd2, x, y, ef, efl);
    model(4'd6, x2, y2, ef2, efl2);
    op = 4'd2; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd6; a = x2; b = y2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== ef || {zf, cf, of, sf, pf} !== efl) begin
        errors++; $display("FAIL backpressure_hold cyc=%0d: ov=%b ir=%b f=%h fl=%b expected 1/0 %h %b", i, out_valid, in_ready, f, {zf, cf, of, sf, pf}, ef, efl);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_retire: ov=%b ir=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || f !== ef2 || {zf, cf, of, sf, pf} !== efl2) begin
      errors++; $display("FAIL backpressure_next: ov=%b f=%h fl=%b expected 1 %h %b", out_valid, f, {zf, cf, of, sf, pf}, ef2, efl2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(4'd7, x, y, gf, gfl);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] gf;
    logic [4:0]   gfl;
    int seen;
    op = 4'd11; a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (f !== '0 || {zf, cf, of, sf, pf} !== 5'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: f=%h fl=%b ov=%b busy=%b ir=%b expected 0/00000/0/0/1", f, {zf, cf, of, sf, pf}, out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_abandon: %0d non-idle cycles expected 0", seen);
    end
    run_op(4'd11, 64'd12345, 64'd678, gf, gfl);
  endtask

  task automatic test_div();
    logic [W-1:0] gf;
    logic [4:0]   gfl;
`ifdef ALU_SEQ_DIV_EN
    run_op(4'd13, 64'd100, 64'd0, gf, gfl);
    checks++;
    if (gf !== {W{1'b1}} || gfl !== 5'b00011) begin
      errors++; $display("FAIL divu_zero: f=%h fl=%b expected all-ones 00011", gf, gfl);
    end
    run_op(4'd14, 64'd100, 64'd7, gf, gfl);
    checks++;
    if (gf !== 64'd2 || gfl !== 5'b00000) begin
      errors++; $display("FAIL remu_plan: f=%h fl=%b expected 2 00000", gf, gfl);
    end
    run_op(4'd14, 64'd100, 64'd0, gf, gfl);
    for (int i = 0; i < 8; i++) begin
      run_op(($urandom_range(0, 1) == 0) ? 4'd13 : 4'd14, {$urandom, $urandom}, 64'($urandom), gf, gfl);
    end
`else
    run_op(4'd13, 64'd100, 64'd7, gf, gfl);
    checks++;
    if (gf !== 64'd0 || gfl !== 5'b10001) begin
      errors++; $display("FAIL divu_disabled: f=%h fl=%b expected 0 10001", gf, gfl);
    end
    run_op(4'd14, 64'd100, 64'd7, gf, gfl);
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] gf, x, y;
    logic [4:0]   gfl;
    logic [3:0]   o;
    for (int i = 0; i < 120; i++) begin
      o = 4'($urandom_range(0, 15));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: y = 64'($urandom_range(0, 70));
        1: x = {1'b0, {(W-1){1'b1}}};
        2: x = {1'b1, {(W-1){1'b0}}};
        3: y = x;
        default: ;
      endcase
      run_op(o, x, y, gf, gfl);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul8();
    test_backpressure();
    test_reset_mid();
    test_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
